// File: rtl/icache_pkg.sv
// Shared line geometry, FSM state type and write-port record for the I-cache refill path.
// VA_BITS defaults to 32 when the build does not define it.
`ifndef VA_BITS
`define VA_BITS 32
`endif

package icache_pkg;

    localparam int IC_LINE_BYTES = 16;
    localparam int IC_WORD_BYTES = 8;
    localparam int IC_BEATS      = IC_LINE_BYTES / IC_WORD_BYTES;
    localparam int IC_TAG_LSB    = 10;
    localparam int IC_IDX_LSB    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        BEATS = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } refill_state_t;

    typedef struct packed {
        logic [`VA_BITS-1:0] addr;
        logic [63:0]         dat;
    } cache_wr_t;

    // Byte address of one 8-byte word within a line; the line bits pass through untouched.
    function automatic logic [`VA_BITS-1:0] word_addr(input logic [`VA_BITS-5:0] line,
                                                     input logic                word);
        return {line, word, 3'b000};
    endfunction

endpackage

// File: rtl/icache_refill.sv
// Purpose: fetches a missing 16-byte I-cache line as two 64-bit beats and writes them into the cache.
// Latency: each accepted beat is written one cycle later; refill_done follows the last write by one cycle.
// Backpressure: mem_req held until mem_gnt; beats have no backpressure; fetch is stalled via refill_busy.
// Optional build macro ICACHE_REFILL_CRITICAL_FIRST_EN: critical word first (wrap order) plus crit_vld.
module icache_refill (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                miss_req,
    input  logic [`VA_BITS-1:0] miss_addr,
    input  logic                flush,
    output logic                mem_req,
    output logic [31:0]         mem_addr,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [63:0]         mem_rdata,
    output logic                write_ff,
    output logic [`VA_BITS-1:0] write_addr_ff,
    output logic [63:0]         write_data_ff,
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    output logic                crit_vld,
`endif
    output logic                refill_busy,
    output logic                refill_done
);

    import icache_pkg::*;

    localparam int LINE_BYTES = IC_LINE_BYTES;
    localparam int BEATS      = LINE_BYTES / IC_WORD_BYTES;
    localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    refill_state_t         state;
    logic [`VA_BITS-5:0]   line_q;
    logic                  first_q;
    logic [CW-1:0]         beat_cnt;
    logic                  wr_vld;
    cache_wr_t             wr_q;
    logic                  done_q;
    logic                  miss_first;
    logic [`VA_BITS-1:0]   req_addr;
    logic [3:0]            unused_miss_low;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    logic                  crit_q;
    assign miss_first = miss_addr[3];
`else
    assign miss_first = 1'b0;
`endif

    // Byte offset bits only steer the word select; the rest are don't-care here.
    assign unused_miss_low = miss_addr[3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            line_q   <= '0;
            first_q  <= 1'b0;
            beat_cnt <= '0;
            wr_vld   <= 1'b0;
            wr_q     <= '0;
            done_q   <= 1'b0;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
            crit_q   <= 1'b0;
`endif
        end else begin
            wr_vld <= 1'b0;
            done_q <= 1'b0;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
            crit_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // The refill_done cycle still counts as busy, so a miss waits one more cycle.
                    if (miss_req && !flush && !done_q) begin
                        line_q  <= miss_addr[`VA_BITS-1:4];
                        first_q <= miss_first;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        beat_cnt <= '0;
                        state    <= flush ? DRAIN : icache_pkg::BEATS;
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                icache_pkg::BEATS: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (!flush) begin
                            wr_vld    <= 1'b1;
                            wr_q.addr <= word_addr(line_q, first_q ^ beat_cnt[0]);
                            wr_q.dat  <= mem_rdata;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
                            crit_q    <= (beat_cnt == '0);
`endif
                        end
                        // A flush on the final beat leaves nothing to drain.
                        if (beat_cnt == LAST_BEAT) begin
                            state <= flush ? IDLE : DONE;
                        end else if (flush) begin
                            state <= DRAIN;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_addr      = word_addr(line_q, first_q);
    assign mem_req       = (state == REQ);
    assign mem_addr      = req_addr[31:0];
    assign write_ff      = wr_vld;
    assign write_addr_ff = wr_q.addr;
    assign write_data_ff = wr_q.dat;
    assign refill_busy   = (state != IDLE) || done_q;
    assign refill_done   = done_q;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    assign crit_vld      = crit_q;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Randomised and directed bench for icache_refill against a line-level reference model.
`ifndef VA_BITS
`define VA_BITS 32
`endif

module tb_icache_refill;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                miss_req = 1'b0;
    logic [`VA_BITS-1:0] miss_addr = '0;
    logic                flush = 1'b0;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_gnt = 1'b0;
    logic                mem_rvalid = 1'b0;
    logic [63:0]         mem_rdata = '0;
    logic                write_ff;
    logic [`VA_BITS-1:0] write_addr_ff;
    logic [63:0]         write_data_ff;
    logic                refill_busy;
    logic                refill_done;
    logic                crit_vld;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] wq_addr[$];
    logic [63:0] wq_dat[$];
    logic        wq_crit[$];
    int          wq_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    icache_refill dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .miss_req      (miss_req),
        .miss_addr     (miss_addr),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .write_ff      (write_ff),
        .write_addr_ff (write_addr_ff),
        .write_data_ff (write_data_ff),
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
        .crit_vld      (crit_vld),
`endif
        .refill_busy   (refill_busy),
        .refill_done   (refill_done)
    );

`ifndef ICACHE_REFILL_CRITICAL_FIRST_EN
    assign crit_vld = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (write_ff) begin
                wq_addr.push_back(64'(write_addr_ff));
                wq_dat.push_back(write_data_ff);
                wq_crit.push_back(crit_vld);
                wq_cyc.push_back(cyc);
            end
            if (refill_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Address written for the k-th beat of the line containing a.
    function automatic logic [63:0] exp_word_addr(input logic [31:0] a, input int k);
        int w;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
        w = (int'(a[3]) + k) % 2;
`else
        w = k;
`endif
        return 64'((a & 32'hFFFF_FFF0) + 32'(w * 8));
    endfunction

    // mode: 0 complete, 1 flush in REQ, 2 flush after beat 0, 3 flush with beat 0
    task automatic run_refill(input logic [31:0] a, input int mode, input int gdly, input int gap_max,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input bit hold, input logic [31:0] other);
        logic [63:0] d[2];
        int nwr;
        int t;
        d[0] = d0;
        d[1] = d1;
        wq_addr.delete(); wq_dat.delete(); wq_crit.delete(); wq_cyc.delete();
        done_cnt = 0;
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = a;
        @(negedge clk);
        if (hold) miss_addr = other;
        else      miss_req = 1'b0;
        chk("req_vld", 64'(mem_req), 64'd1);
        chk("req_addr", 64'(mem_addr), exp_word_addr(a, 0));
        chk("busy_in_req", 64'(refill_busy), 64'd1);
        if (mode == 1) begin
            repeat (gdly) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("flush_req_drop", 64'(mem_req), 64'd0);
            repeat (3) @(negedge clk);
            chk("flush_req_idle", 64'(refill_busy), 64'd0);
        end else begin
            repeat (gdly) @(negedge clk);
            chk("req_hold", 64'(mem_req), 64'd1);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            for (int k = 0; k < 2; k++) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = d[k];
                flush      = (mode == 3 && k == 0);
                @(negedge clk);
                mem_rvalid = 1'b0;
                flush      = 1'b0;
                mem_rdata  = {$urandom, $urandom};
                if (mode == 2 && k == 0) begin
                    flush = 1'b1;
                    @(negedge clk);
                    flush = 1'b0;
                end
            end
            t = 0;
            while (refill_busy && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("idle_timeout", 64'(t < 20), 64'd1);
            if (mode == 0) begin
                chk("busy_drop_after_done", 64'(cyc - done_cyc), 64'd1);
                if (wq_cyc.size() > 0)
                    chk("done_after_last_wr", 64'(done_cyc - wq_cyc[wq_cyc.size()-1]), 64'd1);
            end
            if (hold) begin
                @(negedge clk);
                chk("next_miss_req", 64'(mem_req), 64'd1);
                chk("next_miss_addr", 64'(mem_addr), exp_word_addr(other, 0));
                miss_req = 1'b0;
                flush    = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                @(negedge clk);
                chk("next_miss_flushed", 64'(refill_busy), 64'd0);
            end
        end
        nwr = (mode == 0) ? 2 : (mode == 2) ? 1 : 0;
        chk("write_count", 64'(wq_addr.size()), 64'(nwr));
        for (int i = 0; i < nwr && i < wq_addr.size(); i++) begin
            chk("write_addr", wq_addr[i], exp_word_addr(a, i));
            chk("write_data", wq_dat[i], d[i]);
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
            chk("crit_vld", 64'(wq_crit[i]), 64'(i == 0));
`endif
        end
        if (nwr > 0) chk("write_addr_hold", 64'(write_addr_ff), exp_word_addr(a, nwr - 1));
        chk("done_count", 64'(done_cnt), 64'(mode == 0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_write_ff", 64'(write_ff), 64'd0);
        chk("rst_write_addr", 64'(write_addr_ff), 64'd0);
        chk("rst_write_data", write_data_ff, 64'd0);
        chk("rst_busy", 64'(refill_busy), 64'd0);
        chk("rst_done", 64'(refill_done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_refill(32'h0000_1234, 0, 2, 0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 32'h0);
        run_refill(32'h0000_2000, 1, 1, 0, 64'h1, 64'h2, 1'b0, 32'h0);
        run_refill(32'h0000_3008, 2, 0, 1, 64'h3333_0000_0000_0001, 64'h3333_0000_0000_0002, 1'b0, 32'h0);
        run_refill(32'h0000_4000, 0, 1, 2, 64'h4444_4444_0000_0000, 64'h4444_4444_0000_0001, 1'b1, 32'h0000_5000);
        run_refill(32'h0000_7008, 3, 0, 0, 64'h7, 64'h8, 1'b0, 32'h0);

        // Asynchronous reset while the first beat's write strobe is up.
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = 32'h0000_6000;
        @(negedge clk);
        miss_req = 1'b0;
        mem_gnt  = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h6666_6666_6666_6666;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("pre_reset_write", 64'(write_ff), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_write_ff", 64'(write_ff), 64'd0);
        chk("arst_busy", 64'(refill_busy), 64'd0);
        chk("arst_mem_req", 64'(mem_req), 64'd0);
        chk("arst_write_data", write_data_ff, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_refill(32'h0000_6008, 0, 0, 1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            run_refill($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 2,
                       {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
